// File: rtl/noc_initiator.sv
// Host-side NOC endpoint: serialises read/write requests toward the switch and
// parses read/write responses coming back, tracking transactions in flight.
module noc_initiator #(
  parameter logic [7:0] MY_ID      = 8'h10,
  parameter int         MAX_OUTST  = 4,
  parameter int         WBUF_DEPTH = 128
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [7:0]  req_dest_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_dlen_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  input  logic [7:0]  wdata_i,
  output logic        noc_to_dev_ctl_o,
  output logic [7:0]  noc_to_dev_data_o,
  input  logic        noc_from_dev_ctl_i,
  input  logic [7:0]  noc_from_dev_data_i,
  output logic        rdata_valid_o,
  output logic [7:0]  rdata_o,
  output logic        rdata_last_o,
  output logic [7:0]  rsp_src_o,
  output logic        wr_done_o,
  output logic [7:0]  wr_status_o,
  output logic        rx_err_o,
  output logic [2:0]  outstanding_o
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  // state    | meaning
  // TX_IDLE  | NOP on link, may accept | TX_CMD/DEST/SRC | header bytes
  // TX_ADDR  | 4 address bytes, MSB first | TX_DATA | write payload | TX_GAP | closing NOP
  // RX_IDLE  | wait for command byte (also discards junk) | RX_DEST/SRC | header | RX_BODY | payload
  typedef enum logic [2:0] {
    TX_IDLE, TX_CMD, TX_DEST, TX_SRC, TX_ADDR, TX_DATA, TX_GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_DEST, RX_SRC, RX_BODY
  } rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic [6:0]    tx_cnt_q, tx_cnt_d;
  logic          write_q;
  logic [7:0]    dest_q;
  logic [31:0]   addr_q;
  logic [2:0]    dlen_q;
  logic [6:0]    tx_len_m1;
  logic          accept;
  logic          to_ctl;
  logic [7:0]    to_data;

  logic [7:0]    wbuf_mem [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] wcnt_q;
  logic [CW:0]   wneed;
  logic          push, pop;

  logic          rx_ctl_q;
  logic [7:0]    rx_data_q;
  logic          rx_is_cmd, rx_op_ok, rx_op_rd;
  logic [6:0]    rx_cnt_q, rx_cnt_d;
  logic          rx_rd_q, rx_rd_d;
  logic          rx_match_q, rx_match_d;
  logic [7:0]    rsp_src_q, rsp_src_d;
  logic [7:0]    wr_status_q;
  logic          rd_valid, rd_last, wr_done, err, start_cmd;

  logic [2:0]    outst_q, outst_d;
  logic          issue, complete, orphan;

  // ---------------- request side ----------------
  assign wneed       = (CW+1)'(1) << req_dlen_i;
  assign req_ready_o = !reset_i && (tx_state_q == TX_IDLE) && (outst_q < 3'(MAX_OUTST)) &&
                       (!req_write_i || ({1'b0, wcnt_q} >= wneed));
  assign accept      = req_valid_i && req_ready_o;
  assign tx_len_m1   = 7'((8'd1 << dlen_q) - 8'd1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      write_q <= 1'b0;
      dest_q  <= '0;
      addr_q  <= '0;
      dlen_q  <= '0;
    end else if (accept) begin
      write_q <= req_write_i;
      dest_q  <= req_dest_i;
      addr_q  <= req_addr_i;
      dlen_q  <= req_dlen_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    to_ctl     = 1'b1;
    to_data    = 8'h00;
    case (tx_state_q)
      TX_IDLE: if (accept) tx_state_d = TX_CMD;
      TX_CMD: begin
        to_data    = {2'b10, dlen_q, (write_q ? 3'b010 : 3'b001)};
        tx_state_d = TX_DEST;
      end
      TX_DEST: begin
        to_ctl     = 1'b0;
        to_data    = dest_q;
        tx_state_d = TX_SRC;
      end
      TX_SRC: begin
        to_ctl     = 1'b0;
        to_data    = MY_ID;
        tx_state_d = TX_ADDR;
        tx_cnt_d   = 7'd3;
      end
      TX_ADDR: begin
        to_ctl = 1'b0;
        case (tx_cnt_q[1:0])
          2'd3:    to_data = addr_q[31:24];
          2'd2:    to_data = addr_q[23:16];
          2'd1:    to_data = addr_q[15:8];
          default: to_data = addr_q[7:0];
        endcase
        if (tx_cnt_q == 7'd0) begin
          tx_state_d = write_q ? TX_DATA : TX_GAP;
          tx_cnt_d   = tx_len_m1;
        end else begin
          tx_cnt_d = tx_cnt_q - 7'd1;
        end
      end
      TX_DATA: begin
        to_ctl  = 1'b0;
        to_data = wbuf_mem[rd_ptr_q];
        if (tx_cnt_q == 7'd0) tx_state_d = TX_GAP;
        else                  tx_cnt_d   = tx_cnt_q - 7'd1;
      end
      TX_GAP:  tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign noc_to_dev_ctl_o  = to_ctl;
  assign noc_to_dev_data_o = to_data;

  // ---------------- write payload buffer ----------------
  // Request acceptance waits for the full payload, so DATA never underflows.
  assign wdata_ready_o = !reset_i && (wcnt_q != CW'(WBUF_DEPTH));
  assign push          = wdata_valid_i && wdata_ready_o;
  assign pop           = (tx_state_q == TX_DATA);

  always_ff @(posedge clk_i) begin
    if (push) wbuf_mem[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(WBUF_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(WBUF_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   wcnt_q <= wcnt_q + CW'(1);
        2'b01:   wcnt_q <= wcnt_q - CW'(1);
        default: wcnt_q <= wcnt_q;
      endcase
    end
  end

  // ---------------- response side ----------------
  assign rx_is_cmd = rx_ctl_q && (rx_data_q != 8'h00);
  assign rx_op_rd  = (rx_data_q[2:0] == 3'b011);
  assign rx_op_ok  = rx_op_rd || (rx_data_q[2:0] == 3'b100);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_ctl_q    <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_rd_q     <= 1'b0;
      rx_match_q  <= 1'b0;
      rsp_src_q   <= 8'h00;
      wr_status_q <= 8'h00;
    end else begin
      rx_ctl_q    <= noc_from_dev_ctl_i;
      rx_data_q   <= noc_from_dev_data_i;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_rd_q     <= rx_rd_d;
      rx_match_q  <= rx_match_d;
      rsp_src_q   <= rsp_src_d;
      if (wr_done) wr_status_q <= rx_data_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_rd_d    = rx_rd_q;
    rx_match_d = rx_match_q;
    rsp_src_d  = rsp_src_q;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    wr_done    = 1'b0;
    err        = 1'b0;
    start_cmd  = 1'b0;
    case (rx_state_q)
      RX_IDLE: start_cmd = rx_is_cmd;
      RX_DEST: begin
        if (rx_ctl_q) begin
          err        = 1'b1;
          start_cmd  = rx_is_cmd;
          rx_state_d = RX_IDLE;
        end else begin
          rx_match_d = (rx_data_q == MY_ID);
          rx_state_d = RX_SRC;
        end
      end
      RX_SRC: begin
        if (rx_ctl_q) begin
          err        = rx_match_q;
          start_cmd  = rx_is_cmd;
          rx_state_d = RX_IDLE;
        end else begin
          if (rx_match_q) rsp_src_d = rx_data_q;
          rx_state_d = RX_BODY;
        end
      end
      RX_BODY: begin
        if (rx_ctl_q) begin
          err        = rx_match_q;
          start_cmd  = rx_is_cmd;
          rx_state_d = RX_IDLE;
        end else begin
          if (rx_rd_q) begin
            rd_valid = rx_match_q;
            rd_last  = rx_match_q && (rx_cnt_q == 7'd0);
          end else begin
            wr_done = rx_match_q;
          end
          if (rx_cnt_q == 7'd0) rx_state_d = RX_IDLE;
          else                  rx_cnt_d   = rx_cnt_q - 7'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // A command byte may also cut a truncated packet short; both paths land here.
    if (start_cmd) begin
      if (rx_op_ok) begin
        rx_state_d = RX_DEST;
        rx_rd_d    = rx_op_rd;
        rx_cnt_d   = rx_op_rd ? 7'((8'd1 << rx_data_q[5:3]) - 8'd1) : 7'd0;
      end else begin
        err        = 1'b1;
        rx_state_d = RX_IDLE;
      end
    end
  end

  // ---------------- in-flight accounting ----------------
  assign issue    = (tx_state_q == TX_CMD);
  assign complete = rd_last || wr_done;
  assign orphan   = complete && !issue && (outst_q == 3'd0);

  always_comb begin
    outst_d = outst_q;
    if (issue && !complete)                       outst_d = outst_q + 3'd1;
    else if (complete && !issue && !orphan)       outst_d = outst_q - 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) outst_q <= '0;
    else         outst_q <= outst_d;
  end

  assign rdata_valid_o = !reset_i && rd_valid;
  assign rdata_last_o  = !reset_i && rd_last;
  assign rdata_o       = rx_data_q;
  assign rsp_src_o     = rsp_src_q;
  assign wr_done_o     = !reset_i && wr_done;
  assign wr_status_o   = wr_done ? rx_data_q : wr_status_q;
  assign rx_err_o      = !reset_i && (err || orphan);
  assign outstanding_o = outst_q;

endmodule

// File: tb/tb_noc_initiator.sv
// Directed bench for noc_initiator: a cycle-exact vector table for the main
// read/response flow plus hand-written multi-cycle corner-case sequences.
module tb_noc_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_dest;
  logic [31:0] req_addr;
  logic [2:0]  req_dlen;
  logic        wdata_valid, wdata_ready;
  logic [7:0]  wdata;
  logic        to_ctl, from_ctl;
  logic [7:0]  to_data, from_data;
  logic        rdata_valid, rdata_last, wr_done, rx_err;
  logic [7:0]  rdata, rsp_src, wr_status;
  logic [2:0]  outstanding;

  noc_initiator dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_write_i         (req_write),
    .req_dest_i          (req_dest),
    .req_addr_i          (req_addr),
    .req_dlen_i          (req_dlen),
    .wdata_valid_i       (wdata_valid),
    .wdata_ready_o       (wdata_ready),
    .wdata_i             (wdata),
    .noc_to_dev_ctl_o    (to_ctl),
    .noc_to_dev_data_o   (to_data),
    .noc_from_dev_ctl_i  (from_ctl),
    .noc_from_dev_data_i (from_data),
    .rdata_valid_o       (rdata_valid),
    .rdata_o             (rdata),
    .rdata_last_o        (rdata_last),
    .rsp_src_o           (rsp_src),
    .wr_done_o           (wr_done),
    .wr_status_o         (wr_status),
    .rx_err_o            (rx_err),
    .outstanding_o       (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic        rw;
    logic [7:0]  rd;
    logic [31:0] ra;
    logic [2:0]  rl;
    logic [8:0]  f;
    logic [8:0]  e_tx;
    logic        e_rr;
    logic        e_wr;
    logic        e_rv;
    logic [7:0]  e_rd;
    logic        e_last;
    logic        e_wd;
    logic [7:0]  e_ws;
    logic        e_err;
    logic [2:0]  e_out;
    logic [7:0]  e_src;
  } vec_t;

  localparam int NV = 31;
  vec_t       tbl [NV];
  vec_t       dflt;
  logic [8:0] wexp [12];
  logic [8:0] pq [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         s_rv, s_last, s_wd, s_err, acc;
  logic [7:0] s_ws;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drives pq onto noc_from_dev followed by idle NOPs and tallies response-side pulses.
  task automatic send_rx();
    s_rv = 0; s_last = 0; s_wd = 0; s_err = 0; s_ws = 8'hxx;
    for (int i = 0; i < pq.size() + 3; i++) begin
      if (i < pq.size()) {from_ctl, from_data} = pq[i];
      else               {from_ctl, from_data} = 9'h100;
      #1;
      if (rdata_valid) s_rv++;
      if (rdata_last)  s_last++;
      if (rx_err)      s_err++;
      if (wr_done) begin
        s_wd++;
        s_ws = wr_status;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_dest = 8'h00;
    req_addr = 32'h0; req_dlen = 3'd0; wdata_valid = 1'b0; wdata = 8'h00;
    from_ctl = 1'b1; from_data = 8'h00;

    dflt = '{rst: 1'b0, rv: 1'b0, rw: 1'b0, rd: 8'h00, ra: 32'h0, rl: 3'd0, f: 9'h100,
             e_tx: 9'h100, e_rr: 1'b1, e_wr: 1'b1, e_rv: 1'b0, e_rd: 8'h00, e_last: 1'b0,
             e_wd: 1'b0, e_ws: 8'h00, e_err: 1'b0, e_out: 3'd0, e_src: 8'h00};
    for (int i = 0; i < NV; i++) tbl[i] = dflt;
    tbl[0].rst = 1'b1; tbl[0].e_rr = 1'b0; tbl[0].e_wr = 1'b0;
    tbl[1].rv = 1'b1; tbl[1].rd = 8'h41; tbl[1].ra = 32'h0000_1234; tbl[1].rl = 3'd2;
    for (int i = 2; i <= 9; i++) tbl[i].e_rr = 1'b0;
    // read opcode 001 with dlen 2 gives command byte 8'h91
    tbl[2].e_tx = 9'h191; tbl[3].e_tx = 9'h041; tbl[4].e_tx = 9'h010; tbl[5].e_tx = 9'h000;
    tbl[6].e_tx = 9'h000; tbl[7].e_tx = 9'h012; tbl[8].e_tx = 9'h034;
    for (int i = 3; i <= 21; i++) tbl[i].e_out = 3'd1;
    tbl[10].f = 9'h19B; tbl[11].f = 9'h010; tbl[12].f = 9'h043;
    for (int i = 13; i <= 20; i++) tbl[i].f = {1'b0, 8'(i - 12)};
    for (int i = 14; i <= 21; i++) begin
      tbl[i].e_rv = 1'b1;
      tbl[i].e_rd = 8'(i - 13);
    end
    tbl[21].e_last = 1'b1;
    for (int i = 14; i < NV; i++) tbl[i].e_src = 8'h43;
    for (int i = 26; i < NV; i++) begin
      tbl[i].e_src = 8'h40;
      tbl[i].e_ws  = 8'h5A;
    end
    tbl[22].f = 9'h184; tbl[23].f = 9'h010; tbl[24].f = 9'h040; tbl[25].f = 9'h05A;
    tbl[26].e_wd = 1'b1; tbl[26].e_err = 1'b1;
    tbl[27].f = 9'h18A; tbl[28].f = 9'h055; tbl[28].e_err = 1'b1;

    wexp = '{9'h192, 9'h040, 9'h010, 9'h000, 9'h000, 9'h020, 9'h000,
             9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h100};

    repeat (3) @(negedge clk);

    // ---- table: read request, 8-byte read response, orphan write response, bad opcode
    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst; req_valid = tbl[i].rv; req_write = tbl[i].rw;
      req_dest = tbl[i].rd; req_addr = tbl[i].ra; req_dlen = tbl[i].rl;
      {from_ctl, from_data} = tbl[i].f;
      #1;
      chk($sformatf("v%0d to_dev", i), {to_ctl, to_data}, tbl[i].e_tx);
      chk($sformatf("v%0d req_ready", i), req_ready, tbl[i].e_rr);
      chk($sformatf("v%0d wdata_ready", i), wdata_ready, tbl[i].e_wr);
      chk($sformatf("v%0d rdata_valid", i), rdata_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("v%0d rdata", i), rdata, tbl[i].e_rd);
      chk($sformatf("v%0d rdata_last", i), rdata_last, tbl[i].e_last);
      chk($sformatf("v%0d wr_done", i), wr_done, tbl[i].e_wd);
      chk($sformatf("v%0d wr_status", i), wr_status, tbl[i].e_ws);
      chk($sformatf("v%0d rx_err", i), rx_err, tbl[i].e_err);
      chk($sformatf("v%0d outstanding", i), outstanding, tbl[i].e_out);
      chk($sformatf("v%0d rsp_src", i), rsp_src, tbl[i].e_src);
      @(negedge clk);
    end
    {from_ctl, from_data} = 9'h100;

    // ---- write of 4 bytes with request offered before payload
    req_valid = 1'b1; req_write = 1'b1; req_dest = 8'h40; req_addr = 32'h0000_2000; req_dlen = 3'd2;
    #1; chk("wr no payload req_ready", req_ready, 1'b0);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      wdata_valid = 1'b1;
      wdata = 8'hAA + 8'(b * 17);
      #1; chk($sformatf("wr payload %0d req_ready", b), req_ready, 1'b0);
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    #1; chk("wr payload full req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1; chk($sformatf("wr pkt byte %0d", i), {to_ctl, to_data}, wexp[i]);
      @(negedge clk);
    end
    chk("wr outstanding", outstanding, 3'd1);
    pq = '{9'h184, 9'h010, 9'h040, 9'h000, 9'h100};
    send_rx();
    chk("wr_done count", s_wd, 1);
    chk("wr_status ok", s_ws, 8'h00);
    chk("wr rsp rx_err", s_err, 0);
    chk("wr rsp outstanding", outstanding, 3'd0);

    // ---- fill to MAX_OUTST reads
    req_valid = 1'b1; req_write = 1'b0; req_dest = 8'h42; req_addr = 32'h10; req_dlen = 3'd0;
    acc = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (req_valid && req_ready) acc++;
      @(negedge clk);
      if (acc == 4) req_valid = 1'b0;
    end
    chk("4 reads accepted", acc, 4);
    chk("4 reads outstanding", outstanding, 3'd4);
    chk("4 reads req_ready", req_ready, 1'b0);
    pq = '{9'h183, 9'h010, 9'h041, 9'h077, 9'h100};
    send_rx();
    chk("1-byte rsp rdata_valid", s_rv, 1);
    chk("1-byte rsp rdata_last", s_last, 1);
    chk("after 1 completion outstanding", outstanding, 3'd3);
    chk("after 1 completion req_ready", req_ready, 1'b1);

    // ---- truncated response, foreign response, truncation by a new command
    pq = '{9'h193, 9'h010, 9'h042, 9'h0A1, 9'h0A2, 9'h0A3, 9'h100};
    send_rx();
    chk("trunc rdata_valid", s_rv, 3);
    chk("trunc rdata_last", s_last, 0);
    chk("trunc rx_err", s_err, 1);
    chk("trunc outstanding", outstanding, 3'd3);
    pq = '{9'h183, 9'h022, 9'h044, 9'h055, 9'h100};
    send_rx();
    chk("foreign rdata_valid", s_rv, 0);
    chk("foreign rx_err", s_err, 0);
    chk("foreign outstanding", outstanding, 3'd3);
    chk("foreign rsp_src", rsp_src, 8'h42);
    pq = '{9'h193, 9'h010, 9'h042, 9'h0B1, 9'h183, 9'h010, 9'h041, 9'h0C1, 9'h100};
    send_rx();
    chk("trunc+cmd rx_err", s_err, 1);
    chk("trunc+cmd rdata_valid", s_rv, 2);
    chk("trunc+cmd outstanding", outstanding, 3'd2);

    // ---- issue and completion in the same cycle
    req_write = 1'b0; req_dest = 8'h41; req_addr = 32'h0; req_dlen = 3'd0;
    {from_ctl, from_data} = 9'h183; @(negedge clk);
    {from_ctl, from_data} = 9'h010; @(negedge clk);
    {from_ctl, from_data} = 9'h041; @(negedge clk);
    {from_ctl, from_data} = 9'h066; req_valid = 1'b1;
    #1; chk("same-cycle accept req_ready", req_ready, 1'b1);
    @(negedge clk);
    {from_ctl, from_data} = 9'h100; req_valid = 1'b0;
    #1;
    chk("same-cycle to_dev cmd", {to_ctl, to_data}, 9'h181);
    chk("same-cycle rdata_last", rdata_last, 1'b1);
    chk("same-cycle outstanding before", outstanding, 3'd2);
    @(negedge clk);
    #1;
    chk("same-cycle outstanding after", outstanding, 3'd2);
    chk("same-cycle rx_err", rx_err, 1'b0);
    repeat (10) @(negedge clk);

    // ---- reset during second address byte, with a byte sitting in the write buffer
    wdata_valid = 1'b1; wdata = 8'hEE; @(negedge clk);
    wdata_valid = 1'b0;
    req_valid = 1'b1; req_dest = 8'h40; req_addr = 32'h1122_3344; req_dlen = 3'd1;
    #1; chk("pre-reset accept", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1; chk("addr byte 2", {to_ctl, to_data}, 9'h022);
    reset = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("reset to_dev nop", {to_ctl, to_data}, 9'h100);
    chk("reset outstanding", outstanding, 3'd0);
    chk("reset req_ready", req_ready, 1'b0);
    @(negedge clk);
    #1; chk("reset held req_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; req_write = 1'b1; req_dlen = 3'd0;
    #1; chk("wbuf lost req_ready", req_ready, 1'b0);
    req_write = 1'b0;
    #1; chk("post-reset read req_ready", req_ready, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
